// File: rtl/jtag_types_pkg.sv
// jtag_types_pkg: shared types and constants for the JTAG-driven AHB memory access point
// Provides the AP state enum, command word field offsets, AHB transfer/size codes and status bit indices.
package jtag_types_pkg;
   typedef enum logic [1:0] {IDLE, ADDR, DATA} ahb_ap_state_t;
   localparam int CMD_VALID = 0;
   localparam int CMD_WR = 1;
   localparam int CMD_CTL = 2;
   localparam int CMD_SIZE = 7;
   localparam int CMD_REGSEL = 9;
   localparam int CMD_PAYLOAD = 10;
   localparam int CTL_INC = 0;
   localparam int CTL_CLR = 1;
   localparam logic [1:0] HTRANS_IDLE = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [2:0] HSIZE_WORD = 3'd2;
   localparam logic [2:0] HSIZE_DWORD = 3'd3;
   localparam int ST_BUS_ERR = 0;
   localparam int ST_TIMEOUT = 1;
   localparam int ST_OVERRUN = 2;
endpackage

// File: rtl/ahb_ap_lane_align.sv
// ahb_ap_lane_align: moves the addressed byte lanes of hrdata down to bit 0 and masks to the transfer size
// Ports: hrdata (raw bus data), offset (address bits below the bus width), size (log2 bytes), rdata (aligned result).
module ahb_ap_lane_align #(
   parameter int DATA_W = 32
) (
   input  logic [DATA_W-1:0]             hrdata,
   input  logic [$clog2(DATA_W/8)-1:0]   offset,
   input  logic [1:0]                    size,
   output logic [DATA_W-1:0]             rdata
);
   // a shift of 8<<size at or beyond DATA_W yields zero, so the mask becomes all ones for full-width transfers
   assign rdata = (hrdata >> {offset, 3'b000}) & ~({DATA_W{1'b1}} << (8 << size));
endmodule

// File: rtl/ahb_mem_ap.sv
// ahb_mem_ap: JTAG command driven AHB-Lite single-transfer memory access point
// Ports: AFT_CLK/TRST clock and sync active-low reset; cmd_valid/cmd command input; busy, rsp_valid, rsp_rdata,
// status {overrun, timeout, bus_err} toward JTAG; haddr/htrans/hwrite/hsize/hwdata/hrdata/hready/hresp AHB-Lite master.
module ahb_mem_ap
   import jtag_types_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32,
   parameter int TIMEOUT = 1024,
   parameter int CMD_W = DATA_W + 10
) (
   input  logic               AFT_CLK,
   input  logic               TRST,
   input  logic               cmd_valid,
   input  logic [CMD_W-1:0]   cmd,
   output logic               busy,
   output logic               rsp_valid,
   output logic [DATA_W-1:0]  rsp_rdata,
   output logic [2:0]         status,
   output logic [ADDR_W-1:0]  haddr,
   output logic [1:0]         htrans,
   output logic               hwrite,
   output logic [2:0]         hsize,
   output logic [DATA_W-1:0]  hwdata,
   input  logic [DATA_W-1:0]  hrdata,
   input  logic               hready,
   input  logic               hresp
);
   localparam int LG = $clog2(DATA_W/8);
   localparam logic [1:0] MAX_SIZE = DATA_W == 64 ? HSIZE_DWORD[1:0] : HSIZE_WORD[1:0];
   ahb_ap_state_t state;
   logic [ADDR_W-1:0] tar;
   logic inc_en;
   logic [31:0] tcnt;
   logic [1:0] size;
   logic [2:0] st_set;
   logic [DATA_W-1:0] aligned;
   logic acc, drop, pre_err, tmo, done, unused;
   assign size = cmd[CMD_SIZE +: 2];
   assign acc = cmd_valid && cmd[CMD_VALID] && state == IDLE;
   assign drop = cmd_valid && cmd[CMD_VALID] && state != IDLE;
   assign pre_err = size > MAX_SIZE || (tar & ((ADDR_W'(1) << size) - ADDR_W'(1))) != '0;
   // the counter value is the number of hready-low cycles already seen, so the limit is hit on the TIMEOUT-th one
   assign tmo = TIMEOUT != 0 && state != IDLE && !hready && tcnt == 32'(TIMEOUT - 1);
   assign done = state == DATA && hready && !tmo;
   assign busy = state != IDLE;
   assign unused = ^cmd[CMD_CTL+2 +: 3];
   always_comb begin
      st_set = '0;
      st_set[ST_BUS_ERR] = (acc && cmd[CMD_REGSEL] && pre_err) || (done && hresp);
      st_set[ST_TIMEOUT] = tmo;
      st_set[ST_OVERRUN] = drop;
   end
   ahb_ap_lane_align #(.DATA_W(DATA_W)) u_align (
      .hrdata(hrdata),
      .offset(tar[LG-1:0]),
      .size(hsize[1:0]),
      .rdata(aligned)
   );
   always_ff @(posedge AFT_CLK) begin
      if (!TRST) begin
         state <= IDLE;
         tar <= '0;
         inc_en <= 1'b0;
         tcnt <= '0;
         status <= '0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         haddr <= '0;
         htrans <= HTRANS_IDLE;
         hwrite <= 1'b0;
         hsize <= '0;
         hwdata <= '0;
      end else begin
         rsp_valid <= 1'b0;
         // a clear on the accepted command wipes old flags, then this cycle's flags are merged in
         status <= ((acc && cmd[CMD_CTL+CTL_CLR]) ? 3'b000 : status) | st_set;
         if (tmo) begin
            state <= IDLE;
            htrans <= HTRANS_IDLE;
            rsp_valid <= 1'b1;
            rsp_rdata <= '0;
         end else begin
            case (state)
               IDLE: if (acc) begin
                  if (!cmd[CMD_REGSEL]) begin
                     tar <= cmd[CMD_PAYLOAD +: ADDR_W];
                     inc_en <= cmd[CMD_CTL+CTL_INC];
                  end else if (pre_err) begin
                     rsp_valid <= 1'b1;
                     rsp_rdata <= '0;
                  end else begin
                     state <= ADDR;
                     tcnt <= '0;
                     haddr <= tar;
                     htrans <= HTRANS_NONSEQ;
                     hwrite <= cmd[CMD_WR];
                     hsize <= {1'b0, size};
                     hwdata <= cmd[CMD_PAYLOAD +: DATA_W];
                  end
               end
               ADDR: if (hready) begin
                  state <= DATA;
                  htrans <= HTRANS_IDLE;
               end else tcnt <= tcnt + 32'd1;
               DATA: if (hready) begin
                  state <= IDLE;
                  rsp_valid <= 1'b1;
                  rsp_rdata <= (hresp || hwrite) ? '0 : aligned;
                  if (inc_en && !hresp) tar <= tar + (ADDR_W'(1) << hsize[1:0]);
               end else tcnt <= tcnt + 32'd1;
               default: state <= IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_ahb_mem_ap.sv
// tb_ahb_mem_ap: scoreboard bench for ahb_mem_ap with a behavioural model of TAR, status and response timing
module tb_ahb_mem_ap;
   localparam int TMO = 8;
   typedef struct {logic [31:0] rdata; logic [2:0] st; int cyc;} rsp_t;
   typedef struct {logic [31:0] addr; logic wr; logic [1:0] sz; logic [31:0] wdata;} xfer_t;
   logic clk, trst, cmd_valid, busy, rsp_valid, hwrite, hready, hresp;
   logic [41:0] cmd;
   logic [31:0] rsp_rdata, haddr, hwdata, hrdata;
   logic [2:0] status, hsize;
   logic [1:0] htrans;
   int cyc = 0;
   int n_chk = 0;
   int n_fail = 0;
   rsp_t rq[$];
   xfer_t aq[$];
   logic [31:0] m_tar;
   logic m_inc;
   logic [2:0] m_st;
   ahb_mem_ap #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(TMO)) dut (
      .AFT_CLK(clk), .TRST(trst), .cmd_valid(cmd_valid), .cmd(cmd), .busy(busy),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .status(status), .haddr(haddr),
      .htrans(htrans), .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hrdata(hrdata),
      .hready(hready), .hresp(hresp)
   );
   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end
   always @(posedge clk) cyc <= cyc + 1;
   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask
   function automatic logic [41:0] mk_cmd(logic [31:0] pl, bit rs, logic [1:0] sz, bit clr, bit inc, bit wr);
      return {pl, rs, sz, 3'b000, clr, inc, wr, 1'b1};
   endfunction
   function automatic logic [31:0] ref_read(logic [31:0] rd, logic [31:0] a, int sz);
      longint unsigned v = 64'(rd);
      v = v >> (8 * (a % 4));
      v = v % (64'd1 << (8 * (1 << sz)));
      return v[31:0];
   endfunction
   // response monitor and bus monitor, both driven only by what the DUT presents
   rsp_t r;
   xfer_t x, last_x;
   logic [1:0] prev_htrans = 2'b00;
   always @(negedge clk) begin
      if (rsp_valid) begin
         chk("rsp_expected", 64'(rq.size() != 0), 64'd1);
         if (rq.size() != 0) begin
            r = rq.pop_front();
            chk("rsp_rdata", 64'(rsp_rdata), 64'(r.rdata));
            chk("rsp_cycle", 64'(cyc), 64'(r.cyc));
            chk("rsp_status", 64'(status), 64'(r.st));
         end
      end
      if (htrans == 2'b10 && prev_htrans != 2'b10) begin
         chk("xfer_expected", 64'(aq.size() != 0), 64'd1);
         if (aq.size() != 0) begin
            x = aq.pop_front();
            last_x = x;
            chk("haddr", 64'(haddr), 64'(x.addr));
            chk("hwrite", 64'(hwrite), 64'(x.wr));
            chk("hsize", 64'(hsize), {61'd0, 1'b0, x.sz});
         end
      end
      if (prev_htrans == 2'b10 && htrans == 2'b00 && busy && last_x.wr) chk("hwdata", 64'(hwdata), 64'(last_x.wdata));
      prev_htrans = htrans;
   end
   task automatic wait_rsp();
      for (int i = 0; i < 40 && rq.size() != 0; i++) @(negedge clk);
      chk("rsp_pending", 64'(rq.size()), 64'd0);
      rq.delete();
   endtask
   task automatic addr_cmd(logic [31:0] a, bit inc, bit clr);
      m_tar = a;
      m_inc = inc;
      if (clr) m_st = 3'b000;
      cmd = mk_cmd(a, 0, 2'd0, clr, inc, 0);
      cmd_valid = 1;
      @(negedge clk);
      cmd_valid = 0;
      @(negedge clk);
      chk("addr_status", 64'(status), 64'(m_st));
      chk("addr_busy", 64'(busy), 64'd0);
   endtask
   task automatic data_cmd(bit wr, logic [1:0] sz, logic [31:0] pl, logic [31:0] rd, int wa, int wd, bit err, bit clr, bit dup);
      int n = cyc + 1;
      bit pre = sz > 2 || (m_tar % (32'd1 << sz)) != 0;
      if (clr) m_st = 3'b000;
      if (pre) begin
         m_st[0] = 1;
         rq.push_back('{32'd0, m_st, n});
      end else begin
         aq.push_back('{m_tar, wr, sz, pl});
         if (dup) m_st[2] = 1;
         if (wa + wd >= TMO) begin
            m_st[1] = 1;
            rq.push_back('{32'd0, m_st, n + TMO + (wa < TMO ? 1 : 0)});
         end else begin
            if (err) m_st[0] = 1;
            rq.push_back('{(wr || err) ? 32'd0 : ref_read(rd, m_tar, int'(sz)), m_st, n + 2 + wa + wd});
            if (!err && m_inc) m_tar = m_tar + (32'd1 << sz);
         end
      end
      hrdata = rd;
      hresp = 0;
      hready = 1;
      cmd = mk_cmd(pl, 1, sz, clr, 0, wr);
      cmd_valid = 1;
      @(negedge clk);
      cmd_valid = dup;
      if (!pre) for (int k = 0; k <= wa + wd + 1; k++) begin
         hready = !(k < wa || (k > wa && k <= wa + wd));
         hresp = err && k == wa + wd + 1;
         @(negedge clk);
         cmd_valid = 0;
      end
      hready = 1;
      hresp = 0;
      cmd_valid = 0;
      wait_rsp();
      chk("data_status", 64'(status), 64'(m_st));
      chk("data_busy", 64'(busy), 64'd0);
   endtask
   task automatic reset_mid();
      addr_cmd(32'h3000, 1, 0);
      aq.push_back('{32'h3000, 1'b1, 2'd2, 32'h5A5A_0001});
      cmd = mk_cmd(32'h5A5A_0001, 1, 2'd2, 0, 0, 1);
      cmd_valid = 1;
      @(negedge clk);
      cmd_valid = 0;
      hready = 1;
      @(negedge clk);
      hready = 0;
      repeat (2) @(negedge clk);
      trst = 0;
      @(negedge clk);
      chk("rst_htrans", 64'(htrans), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_status", 64'(status), 64'd0);
      chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      trst = 1;
      hready = 1;
      m_tar = 0;
      m_inc = 0;
      m_st = 0;
      repeat (2) @(negedge clk);
   endtask
   initial begin
      trst = 0;
      cmd_valid = 0;
      cmd = '0;
      hready = 1;
      hresp = 0;
      hrdata = '0;
      m_tar = 0;
      m_inc = 0;
      m_st = 0;
      repeat (3) @(negedge clk);
      chk("reset_busy", 64'(busy), 64'd0);
      chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("reset_status", 64'(status), 64'd0);
      chk("reset_htrans", 64'(htrans), 64'd0);
      chk("reset_haddr", 64'(haddr), 64'd0);
      chk("reset_rdata", 64'(rsp_rdata), 64'd0);
      trst = 1;
      @(negedge clk);
      addr_cmd(32'h1000, 1, 0);
      data_cmd(1, 2'd2, 32'hA, 32'h0, 0, 0, 0, 0, 0);
      data_cmd(1, 2'd2, 32'hB, 32'h0, 0, 0, 0, 0, 0);
      data_cmd(1, 2'd2, 32'hC, 32'h0, 0, 0, 0, 0, 0);
      addr_cmd(32'h2002, 0, 0);
      data_cmd(0, 2'd1, 32'h0, 32'hBEEF_1234, 0, 0, 0, 0, 0);
      addr_cmd(32'h2001, 0, 0);
      data_cmd(0, 2'd2, 32'h0, 32'h1111_2222, 0, 0, 0, 0, 0);
      data_cmd(0, 2'd0, 32'h0, 32'hAABB_CCDD, 1, 1, 0, 0, 0);
      data_cmd(0, 2'd2, 32'h0, 32'h0, 10, 0, 0, 1, 0);
      data_cmd(0, 2'd2, 32'h0, 32'h0, 3, 6, 0, 0, 0);
      addr_cmd(32'h4000, 0, 1);
      data_cmd(1, 2'd2, 32'h1234_5678, 32'h0, 0, 0, 0, 0, 1);
      data_cmd(0, 2'd2, 32'h0, 32'hCAFE_F00D, 0, 0, 0, 1, 0);
      data_cmd(0, 2'd2, 32'h0, 32'h0, 0, 2, 1, 0, 0);
      reset_mid();
      data_cmd(1, 2'd2, 32'h7777, 32'h0, 0, 0, 0, 0, 0);
      addr_cmd(32'hFFFF_FFFC, 1, 0);
      data_cmd(1, 2'd2, 32'h1, 32'h0, 0, 0, 0, 0, 0);
      data_cmd(1, 2'd2, 32'h2, 32'h0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 250; i++) begin
         if ($urandom_range(0, 4) == 0) begin
            logic [31:0] a = $urandom;
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            if ($urandom_range(0, 7) == 0) a[31:4] = '1;
            addr_cmd(a, 1'($urandom_range(0, 1)), $urandom_range(0, 5) == 0);
         end else begin
            int wa = $urandom_range(0, 2);
            int wd = $urandom_range(0, 2);
            logic [1:0] sz = $urandom_range(0, 9) == 0 ? 2'd3 : 2'($urandom_range(0, 2));
            if ($urandom_range(0, 9) == 0) begin
               wa = $urandom_range(0, 10);
               wd = $urandom_range(0, 10);
            end
            data_cmd(1'($urandom_range(0, 1)), sz, $urandom, $urandom, wa, wd,
                     $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0, 0);
         end
      end
      repeat (3) @(negedge clk);
      chk("xfer_pending", 64'(aq.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/ahb_mem_ap.md
Name: ahb_mem_ap

Overview:
Parametrised AHB-Lite memory access point driven by the JTAG debug chain. It takes a packed command word from the DR-scan side, holding a transfer-address register (TAR) and issuing single AHB-Lite read/write transfers. It adds the following on top of a basic access point:
- configurable data and address widths
- size-based address auto-increment
- byte-lane alignment of read data
- an HREADY timeout
- sticky error/overrun status

Parameters:
DATA_W, 32, AHB data width; 32 or 64.
ADDR_W, 32, AHB address width.
TIMEOUT, 1024, max consecutive HREADY-low cycles per transfer; 0 disables the timeout.
CMD_W, DATA_W+10, command word width (derived; do not override).

Ports:
AFT_CLK  in  1  single clock, rising edge.
TRST  in  1  synchronous, active-low reset.
cmd_valid  in  1  command strobe from the JTAG side.
cmd  in  CMD_W  [CMD_W-1:10] payload, [9] reg_sel, [8:7] size, [6:2] ctl (ctl[0]=inc_en, ctl[1]=clr_status, rest reserved), [1] wr, [0] valid.
busy  out  1  high in any state other than IDLE.
rsp_valid  out  1  one-cycle pulse when a data command completes.
rsp_rdata  out  DATA_W  aligned read data; 0 for writes and errors.
status  out  3  sticky {overrun, timeout, bus_err}.
haddr  out  ADDR_W
htrans  out  2  IDLE=2'b00 or NONSEQ=2'b10 only.
hwrite  out  1
hsize  out  3  {1'b0, size}.
hwdata  out  DATA_W
hrdata  in  DATA_W
hready  in  1
hresp  in  1  1 = ERROR.

Behaviour:
- Reset: clocked on AFT_CLK with TRST==0. All outputs, TAR, inc_en, status and the timeout counter go to 0; state goes to IDLE.
  - Reset mid-transfer aborts immediately: htrans=IDLE on the next cycle, and no rsp_valid is generated.
- Acceptance: a command is accepted only when cmd_valid && cmd[0] && state==IDLE.
  - cmd_valid && cmd[0] while busy: the command is dropped and status[2] is set.
  - Any accepted command with ctl[1]=1 clears status before any new flags from that command are applied.
- reg_sel=0 (address command):
  - TAR <= payload[ADDR_W-1:0]; inc_en <= ctl[0].
  - State stays IDLE; no bus activity and no rsp_valid.
- reg_sel=1 (data command), pre-check on the acceptance cycle:
  - Error if size > log2(DATA_W/8), or if TAR is not aligned to 2^size.
  - On error: set status[0], pulse rsp_valid on the next cycle with rsp_rdata=0, issue no transfer, TAR unchanged.
- States: IDLE -> ADDR -> DATA -> IDLE.
  - ADDR (entered the cycle after acceptance): haddr=TAR, htrans=NONSEQ, hwrite=wr, hsize set. Hold while hready=0; move to DATA on hready=1.
  - DATA: htrans=IDLE. hwdata=payload held for the whole state. Hold while hready=0.
  - On hready=1 in DATA: capture read data, apply hresp, return to IDLE.
  - rsp_valid pulses in the cycle after the final hready, so latency is 3 cycles from acceptance with zero wait states.
- Read alignment: rsp_rdata = (hrdata >> 8*TAR[log2(DATA_W/8)-1:0]) masked to 2^size bytes.
- Bus error: hresp=1 on the completing cycle sets status[0] and forces rsp_rdata=0.
- Auto-increment: after a completed data transfer with inc_en=1, TAR <= TAR + 2^size, wrapping modulo 2^ADDR_W.
  - TAR is not incremented on a pre-check error, bus error or timeout.
- Timeout: the counter clears on entry to ADDR and counts hready-low cycles across ADDR and DATA.
  - When the count reaches TIMEOUT: set status[1], force htrans=IDLE, go to IDLE, pulse rsp_valid with rsp_rdata=0.

Decomposition:
- Add ahb_ap_state_t (IDLE, ADDR, DATA) to jtag_types_pkg.
- Also add to jtag_types_pkg: cmd field offsets, HTRANS_IDLE/HTRANS_NONSEQ, HSIZE constants, status bit indices.
- One sub-module, ahb_ap_lane_align: combinational shift/mask of hrdata by address offset and size, parametrised on DATA_W.

Test Plan:
1. Address command payload 0x1000, inc_en=1; then 3 data writes, size=2, payloads 0xA,0xB,0xC, hready always 1 -> haddr 0x1000, 0x1004, 0x1008; each rsp_valid 3 cycles after acceptance; status=0.
2. TAR=0x2002, read size=1, hrdata=0xBEEF1234 -> rsp_rdata=0x0000BEEF.
3. TAR=0x2001, read size=2 -> no NONSEQ issued, status=3'b001, rsp_rdata=0, TAR stays 0x2001.
4. TIMEOUT=8, hready held 0 in ADDR -> after 8 cycles htrans=IDLE, status[1]=1, rsp_valid pulse, busy=0.
5. Second data command in the cycle after acceptance -> dropped, status[2]=1, only one transfer issued. Next command with clr_status -> status=0.
6. TRST=0 while in DATA with hready=0 -> next cycle htrans=0, busy=0, TAR=0, no rsp_valid. TAR=0xFFFFFFFC with inc_en, size=2 write -> TAR wraps to 0x0.
